// File: rtl/lsu_dmem_adapter.sv
// Load/store adapter between the MEM stage and a 64-bit word-organised dmem.
// Splits word-crossing loads into two reads and word-crossing stores into
// single-byte writes; returns extended load data and flags out-of-range
// accesses.
module lsu_dmem_adapter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [11:0]  dm_wordAddr,
  output logic [2:0]   dm_byteOffset,
  output logic [2:0]   dm_memWidth,
  output logic         dm_readEnable,
  output logic         dm_writeEnable,
  output logic [N-1:0] dm_writeData,
  input  logic [N-1:0] dm_readData
);

  typedef enum logic [1:0] {IDLE, LD2, STB, RESP} state_t;

  state_t       state;
  logic [14:0]  addr_q;
  logic [N-1:0] wdata_q;
  logic [2:0]   f3_q;
  logic [2:0]   cnt_q;
  logic [N-1:0] part_q;
  logic [N-1:0] rdata_q;
  logic         fault_q;

  logic [3:0]   req_size;
  logic         req_fault;
  logic         req_cross;
  logic [N-1:0] rd_shift;
  logic [3:0]   q_size;
  logic [14:0]  stb_addr;
  logic [7:0]   stb_byte;
  logic         stb_last;
  logic [6:0]   ld2_shamt;
  logic [N-1:0] ld2_data;

  // Sign- or zero-extend the low 1/2/4 bytes; the 8-byte size passes through.
  function automatic logic [N-1:0] extend(input logic [N-1:0] raw, input logic [2:0] f3);
    logic sx;
    sx = ~f3[2];
    case (f3[1:0])
      2'd0:    extend = {{(N-8){sx & raw[7]}}, raw[7:0]};
      2'd1:    extend = {{(N-16){sx & raw[15]}}, raw[15:0]};
      2'd2:    extend = {{(N-32){sx & raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  // Request decode: size, fault and word-crossing classification.
  always_comb begin
    req_size  = 4'd1 << req_funct3[1:0];
    req_fault = (req_addr[N-1:15] != '0) ||
                (({1'b0, req_addr[14:0]} + {12'd0, req_size} - 16'd1) > 16'h7FFF);
    req_cross = ({1'b0, req_addr[2:0]} + req_size) > 4'd8;
    rd_shift  = dm_readData >> {req_addr[2:0], 3'b000};
  end

  // Split-access helpers derived from the latched request.
  always_comb begin
    q_size    = 4'd1 << f3_q[1:0];
    stb_addr  = addr_q + {12'd0, cnt_q};
    stb_byte  = wdata_q[{cnt_q, 3'b000} +: 8];
    stb_last  = ({1'b0, cnt_q} == (q_size - 4'd1));
    // second word supplies the bytes above the (8 - off) already latched
    ld2_shamt = {(4'd8 - {1'b0, addr_q[2:0]}), 3'b000};
    ld2_data  = part_q | (dm_readData << ld2_shamt);
  end

  // dmem request outputs: direct from the request in IDLE, from latched state
  // during split accesses, zero otherwise.
  always_comb begin
    dm_wordAddr    = '0;
    dm_byteOffset  = '0;
    dm_memWidth    = '0;
    dm_readEnable  = 1'b0;
    dm_writeEnable = 1'b0;
    dm_writeData   = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid && !req_fault) begin
            dm_wordAddr   = req_addr[14:3];
            dm_byteOffset = req_addr[2:0];
            if (req_write) begin
              dm_writeEnable = 1'b1;
              if (req_cross) begin
                dm_memWidth  = 3'd0;
                dm_writeData = {{(N-8){1'b0}}, req_wdata[7:0]};
              end else begin
                dm_memWidth  = {1'b0, req_funct3[1:0]};
                dm_writeData = extend(req_wdata, {1'b1, req_funct3[1:0]});
              end
            end else begin
              dm_readEnable = 1'b1;
              dm_memWidth   = {1'b0, req_funct3[1:0]};
            end
          end
        end
        LD2: begin
          dm_readEnable = 1'b1;
          dm_wordAddr   = addr_q[14:3] + 12'd1;
          dm_byteOffset = 3'd0;
          dm_memWidth   = {1'b0, f3_q[1:0]};
        end
        STB: begin
          dm_writeEnable = 1'b1;
          dm_wordAddr    = stb_addr[14:3];
          dm_byteOffset  = stb_addr[2:0];
          dm_memWidth    = 3'd0;
          dm_writeData   = {{(N-8){1'b0}}, stb_byte};
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered response data/fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      part_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr[14:0];
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            rdata_q <= '0;
            if (req_fault) begin
              state <= RESP;
            end else if (!req_cross) begin
              if (!req_write) rdata_q <= extend(rd_shift, req_funct3);
              state <= RESP;
            end else if (req_write) begin
              cnt_q <= 3'd1;
              state <= STB;
            end else begin
              part_q <= rd_shift;
              state  <= LD2;
            end
          end
        end
        LD2: begin
          rdata_q <= extend(ld2_data, f3_q);
          state   <= RESP;
        end
        STB: begin
          if (stb_last) state <= RESP;
          else          cnt_q <= cnt_q + 3'd1;
        end
        RESP: begin
          rdata_q <= '0;
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response and handshake outputs decoded from registered state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = rdata_q;
    resp_fault = fault_q;
  end

endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// Bench for lsu_dmem_adapter: a dmem stub, a byte-array reference model,
// a vector table, hand-written split/reset/back-to-back sequences and a
// randomized run.
module tb_lsu_dmem_adapter;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_fault;
  logic [N-1:0] resp_rdata;
  logic [11:0]  dm_wordAddr;
  logic [2:0]   dm_byteOffset, dm_memWidth;
  logic         dm_readEnable, dm_writeEnable;
  logic [N-1:0] dm_writeData, dm_readData;

  always #5 clk = ~clk;

  lsu_dmem_adapter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dm_wordAddr(dm_wordAddr), .dm_byteOffset(dm_byteOffset), .dm_memWidth(dm_memWidth),
    .dm_readEnable(dm_readEnable), .dm_writeEnable(dm_writeEnable),
    .dm_writeData(dm_writeData), .dm_readData(dm_readData)
  );

  // dmem stub
  logic [63:0] mem [0:4095];
  logic        clr, pre_we;
  logic [11:0] pre_w;
  logic [63:0] pre_d;
  assign dm_readData = mem[dm_wordAddr];

  typedef struct {
    logic [11:0] w;
    logic [2:0]  off;
    logic [2:0]  width;
    logic [7:0]  b;
    int          cyc;
  } wlog_t;
  wlog_t wlog[$];
  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resp_valid)    resp_cnt <= resp_cnt + 1;
    if (dm_readEnable) rd_cnt <= rd_cnt + 1;
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_w] <= pre_d;
    end else if (dm_writeEnable) begin
      wr_cnt <= wr_cnt + 1;
      wlog.push_back('{dm_wordAddr, dm_byteOffset, dm_memWidth, dm_writeData[7:0], cyc});
      for (int i = 0; i < (1 << dm_memWidth[1:0]); i++)
        if (int'(dm_byteOffset) + i < 8)
          mem[dm_wordAddr][8*(int'(dm_byteOffset)+i) +: 8] <= dm_writeData[8*i +: 8];
    end
  end

  // reference model: flat byte array with plain arithmetic
  logic [7:0] refm [0:32767];

  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_fault(input logic [63:0] a, input logic [2:0] f3);
    if ((a >> 15) != 0) return 1'b1;
    return (a + 64'(ref_size(f3)) - 64'd1) > 64'h7FFF;
  endfunction

  function automatic logic ref_cross(input logic [63:0] a, input logic [2:0] f3);
    return (int'(a[2:0]) + ref_size(f3)) > 8;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] v;
    int sz;
    sz = ref_size(f3);
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = refm[int'(a[14:0]) + i];
    if (sz < 8 && !f3[2] && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d);
    for (int i = 0; i < ref_size(f3); i++) refm[int'(a[14:0]) + i] = d[8*i +: 8];
  endtask

  function automatic int ref_lat(input logic w, input logic [63:0] a, input logic [2:0] f3);
    if (ref_fault(a, f3) || !ref_cross(a, f3)) return 1;
    return w ? ref_size(f3) : 2;
  endfunction

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h want 0x%h", nm, got, exp);
    end
  endtask

  task automatic set_word(input logic [11:0] w, input logic [63:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_w = w; pre_d = d;
    for (int i = 0; i < 8; i++) refm[int'(w)*8 + i] = d[8*i +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rdata, output logic fault,
                        output int lat, output int rds, output int wrs, output logic extra);
    int guard, r0, w0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    r0 = rd_cnt; w0 = wr_cnt;
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata; fault = resp_fault;
    @(posedge clk); #1;
    extra = resp_valid;
    rds = rd_cnt - r0; wrs = wr_cnt - w0;
  endtask

  typedef struct {
    string       nm;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          rds;
    int          wrs;
  } vec_t;

  vec_t tbl [16];

  logic [63:0] g_rdata;
  logic        g_fault, g_extra;
  int          g_lat, g_rds, g_wrs;

  initial begin
    tbl[0]  = '{"ld_aligned",  1'b0, 3'd3, 64'h28,   64'h0, 64'h8877665544332211, 1'b0, 1, 1, 0};
    tbl[1]  = '{"lh_cross",    1'b0, 3'd1, 64'h07,   64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2, 2, 0};
    tbl[2]  = '{"lhu_cross",   1'b0, 3'd5, 64'h07,   64'h0, 64'h000000000000FF80, 1'b0, 2, 2, 0};
    tbl[3]  = '{"lw_sext",     1'b0, 3'd2, 64'h2C,   64'h0, 64'hFFFFFFFF88776655, 1'b0, 1, 1, 0};
    tbl[4]  = '{"lwu",         1'b0, 3'd6, 64'h2C,   64'h0, 64'h0000000088776655, 1'b0, 1, 1, 0};
    tbl[5]  = '{"ld_cross",    1'b0, 3'd3, 64'h2B,   64'h0, 64'h0000008877665544, 1'b0, 2, 2, 0};
    tbl[6]  = '{"ld_fault",    1'b0, 3'd3, 64'h7FFC, 64'h0, 64'h0,                1'b1, 1, 0, 0};
    tbl[7]  = '{"sb_fault",    1'b1, 3'd0, 64'h8000, 64'h77, 64'h0,               1'b1, 1, 0, 0};
    tbl[8]  = '{"ld_top",      1'b0, 3'd3, 64'h7FF8, 64'h0, 64'h0,                1'b0, 1, 1, 0};
    tbl[9]  = '{"lh_top_flt",  1'b0, 3'd1, 64'h7FFF, 64'h0, 64'h0,                1'b1, 1, 0, 0};
    tbl[10] = '{"sb_c5",       1'b1, 3'd0, 64'h20,   64'hDEADBEEF000000C5, 64'h0, 1'b0, 1, 0, 1};
    tbl[11] = '{"lb_c5",       1'b0, 3'd0, 64'h20,   64'h0, 64'hFFFFFFFFFFFFFFC5, 1'b0, 1, 1, 0};
    tbl[12] = '{"lbu_c5",      1'b0, 3'd4, 64'h20,   64'h0, 64'h00000000000000C5, 1'b0, 1, 1, 0};
    tbl[13] = '{"f3_7_as_d",   1'b0, 3'd7, 64'h28,   64'h0, 64'h8877665544332211, 1'b0, 1, 1, 0};
    tbl[14] = '{"sh_cross",    1'b1, 3'd5, 64'h3F,   64'h1234BEEF, 64'h0,         1'b0, 2, 0, 2};
    tbl[15] = '{"lhu_3f",      1'b0, 3'd5, 64'h3F,   64'h0, 64'h000000000000BEEF, 1'b0, 2, 2, 0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; clr = 1'b0; pre_we = 1'b0; pre_w = '0; pre_d = '0;
    for (int i = 0; i < 32768; i++) refm[i] = '0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp", {resp_valid, resp_fault}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_dm", {dm_wordAddr, dm_byteOffset, dm_memWidth, dm_readEnable, dm_writeEnable},
        64'd0);
    chk("rst_wdata", dm_writeData, 64'd0);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    set_word(12'd0, 64'h8000060504030201);
    set_word(12'd1, 64'hA5A5A5A5A5A500FF);
    set_word(12'd2, 64'h123456789ABCDEF0);
    set_word(12'd5, 64'h8877665544332211);
    @(negedge clk); reset = 1'b0;

    // vector table
    for (int v = 0; v < 16; v++) begin
      do_req(tbl[v].w, tbl[v].f3, tbl[v].addr, tbl[v].wdata,
             g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk({tbl[v].nm, "_rdata"}, g_rdata, tbl[v].rdata);
      chk({tbl[v].nm, "_fault"}, 64'(g_fault), 64'(tbl[v].fault));
      chk({tbl[v].nm, "_lat"}, 64'(g_lat), 64'(tbl[v].lat));
      chk({tbl[v].nm, "_reads"}, 64'(g_rds), 64'(tbl[v].rds));
      chk({tbl[v].nm, "_writes"}, 64'(g_wrs), 64'(tbl[v].wrs));
      chk({tbl[v].nm, "_pulse"}, 64'(g_extra), 64'd0);
      if (tbl[v].w && !tbl[v].fault) ref_store(tbl[v].addr, tbl[v].f3, tbl[v].wdata);
    end

    // crossing sw: four single-byte writes in consecutive cycles
    begin
      logic [11:0] ew [4];
      logic [2:0]  eo [4];
      logic [7:0]  eb [4];
      ew = '{12'd0, 12'd0, 12'd1, 12'd1};
      eo = '{3'd6, 3'd7, 3'd0, 3'd1};
      eb = '{8'h44, 8'h33, 8'h22, 8'h11};
      wlog.delete();
      do_req(1'b1, 3'd2, 64'h06, 64'h11223344, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk("sw_cross_lat", 64'(g_lat), 64'd4);
      chk("sw_cross_resp", {g_rdata[62:0], g_fault}, 64'd0);
      chk("sw_cross_nwr", 64'(wlog.size()), 64'd4);
      if (wlog.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("sw_cross_byte%0d", i),
              {wlog[i].w, wlog[i].off, wlog[i].width, wlog[i].b},
              {ew[i], eo[i], 3'd0, eb[i]});
          chk($sformatf("sw_cross_cyc%0d", i), 64'(wlog[i].cyc - wlog[0].cyc), 64'(i));
        end
      end
      ref_store(64'h06, 3'd2, 64'h11223344);
      do_req(1'b0, 3'd3, 64'h00, 64'h0, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk("sw_cross_word0", g_rdata, 64'h3344060504030201);
      do_req(1'b0, 3'd3, 64'h08, 64'h0, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk("sw_cross_word1", g_rdata, 64'hA5A5A5A5A5A51122);
    end

    // reset in the middle of a split sd at 0x03, after two byte writes
    begin
      int rc0;
      @(negedge clk);
      rc0 = resp_cnt;
      req_write = 1'b1; req_funct3 = 3'd3; req_addr = 64'h03;
      req_wdata = 64'hF8F7F6F5F4F3F2F1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midrst_ready", 64'(req_ready), 64'd1);
      chk("midrst_resp", {resp_valid, resp_fault}, 64'd0);
      chk("midrst_rdata", resp_rdata, 64'd0);
      chk("midrst_dm", {dm_wordAddr, dm_byteOffset, dm_memWidth, dm_readEnable, dm_writeEnable},
          64'd0);
      chk("midrst_wdata", dm_writeData, 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_noresp", 64'(resp_cnt - rc0), 64'd0);
      refm[3] = 8'hF1; refm[4] = 8'hF2;
      do_req(1'b0, 3'd2, 64'h10, 64'h0, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk("after_rst_lw", g_rdata, 64'hFFFFFFFF9ABCDEF0);
      chk("after_rst_lw_lat", 64'(g_lat), 64'd1);
      do_req(1'b0, 3'd3, 64'h00, 64'h0, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk("midrst_partial", g_rdata, 64'h334406F2F1030201);
    end

    // back-to-back with req_valid held high
    begin
      int rc0;
      @(negedge clk);
      rc0 = resp_cnt;
      req_write = 1'b1; req_funct3 = 3'd0; req_addr = 64'h20; req_wdata = 64'hAB; req_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_ready_resp", 64'(req_ready), 64'd0);
      chk("b2b_resp1", 64'(resp_valid), 64'd1);
      req_write = 1'b0; req_funct3 = 3'd4; req_wdata = '0;
      @(posedge clk); #1;
      chk("b2b_ready_idle", 64'(req_ready), 64'd1);
      chk("b2b_gap", 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
      chk("b2b_resp2", 64'(resp_valid), 64'd1);
      chk("b2b_lbu", resp_rdata, 64'hAB);
      @(posedge clk); #1;
      chk("b2b_npulse", 64'(resp_cnt - rc0), 64'd2);
      ref_store(64'h20, 3'd0, 64'hAB);
    end

    // randomized requests against the reference model
    for (int n = 0; n < 400; n++) begin
      logic        w, efault;
      logic [2:0]  f3;
      logic [63:0] a, d, erd;
      int          sel, elat, erds, ewrs;
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 64'($urandom_range(0, 255));
      else if (sel < 9) a = 64'h7FF0 + 64'($urandom_range(0, 15));
      else              a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      efault = ref_fault(a, f3);
      elat = ref_lat(w, a, f3);
      erd = (w || efault) ? 64'd0 : ref_load(a, f3);
      erds = (w || efault) ? 0 : (ref_cross(a, f3) ? 2 : 1);
      ewrs = (!w || efault) ? 0 : (ref_cross(a, f3) ? ref_size(f3) : 1);
      do_req(w, f3, a, d, g_rdata, g_fault, g_lat, g_rds, g_wrs, g_extra);
      chk($sformatf("rnd%0d_rdata", n), g_rdata, erd);
      chk($sformatf("rnd%0d_fault", n), 64'(g_fault), 64'(efault));
      chk($sformatf("rnd%0d_lat", n), 64'(g_lat), 64'(elat));
      chk($sformatf("rnd%0d_acc", n), {32'(g_rds), 32'(g_wrs)}, {32'(erds), 32'(ewrs)});
      if (w && !efault) ref_store(a, f3, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_adapter.md
# lsu_dmem_adapter

Load/store unit sitting directly upstream of the data memory (`dmem`). It accepts byte-addressed load/store requests from the MEM stage and translates them into `dmem` word/offset/width accesses. Accesses crossing a 64-bit word boundary are split: loads become two reads, and stores become a sequence of single-byte writes. It returns sign- or zero-extended load data and flags out-of-range accesses.

## Interface
- N, 64, data width; only N=64 is supported.
- clk  in  1  clock; `dmem` writes occur on the same edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  adapter idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size code:
  - 0 = b, 1 = h, 2 = w, 3 = d.
  - 4 = bu, 5 = hu, 6 = wu.
  - 7 is treated as d.
  - For stores, bit 2 is ignored.
- req_addr  in  N  byte address.
- req_wdata  in  N  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  N  extended load data; 0 for stores and faults.
- resp_fault  out  1  access fault; valid with resp_valid.
- dm_wordAddr  out  12  to `dmem` wordAddr.
- dm_byteOffset  out  3  to `dmem` byteOffset.
- dm_memWidth  out  3  to `dmem` memWidth, using the same funct3 encoding (0/1/2/3).
- dm_readEnable  out  1  to `dmem` readEnable.
- dm_writeEnable  out  1  to `dmem` writeEnable.
- dm_writeData  out  N  right-aligned data; `dmem` shifts it by byteOffset.
- dm_readData  in  N  combinational `dmem` read of dm_wordAddr.

## Operation
- **Access size.** size = 1/2/4/8 bytes from funct3[1:0].
- **Address mapping.** word = addr[14:3], off = addr[2:0].
- **Fault.** An access faults if addr[N-1:15] ≠ 0 or addr + size − 1 > 0x7FFF.
  - A faulting request causes no `dmem` access.
  - It completes as resp_valid=1, resp_fault=1, resp_rdata=0.
- **Crossing.** An access crosses a word boundary when off + size > 8. Otherwise it is "simple".
- **States:** IDLE, LD2, STB, RESP.
- **IDLE.** req_ready=1. On req_valid:
  - Fault or simple store/load: issue the access this cycle → RESP.
    - Stores: dm_writeEnable=1, width = size.
    - Loads: dm_readEnable=1; latch dm_readData.
  - Crossing load: read word k, latch its upper (8 − off) bytes → LD2.
  - Crossing store: write byte 0 at (k, off), memWidth=0 → STB. Latch addr, wdata, size, and byte count cnt=1.
- **LD2.** Read word k+1 at offset 0, latch the low (size − 8 + off) bytes, assemble little-endian → RESP.
- **STB.** Write byte cnt of wdata to byte address addr+cnt, memWidth=0, byteOffset=(addr+cnt)[2:0], wordAddr follows the carry into k+1. Increment cnt. After byte size−1 is written → RESP.
- **RESP.** resp_valid=1 with registered rdata/fault → IDLE; req_ready=0 this cycle.
- **Extension.**
  - Signed loads sign-extend from bit 8·size−1.
  - Unsigned loads (bu/hu/wu) zero-extend.
  - d is passed through unchanged.
- **Idle outputs.** When not accessing: dm_readEnable=dm_writeEnable=0; dm_wordAddr, dm_byteOffset, dm_memWidth, dm_writeData = 0.
- **Reset.** Asserting reset in any state forces IDLE immediately.
  - An in-flight split store may remain partially written; no response is issued.
  - Reset values: req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, and all dm_* outputs 0.

## Timing
- Request accepted on the rising edge where req_valid & req_ready.
- The `dmem` request outputs are combinational from the request inputs while in IDLE. Upstream must hold the request stable that cycle.
- Latency from accept edge to resp_valid:
  - Simple access or fault: 1 cycle.
  - Crossing load: 2 cycles.
  - Crossing store of size s: s cycles (s byte writes, last write in cycle s−1, resp in cycle s).
- Throughput is one request per (latency + 1) cycles; req_ready is low from accept until after the RESP cycle.
- There is no response backpressure; resp_valid is a single-cycle pulse.

## Test plan
- **Aligned ld.**
  - Stimulus: memory word 5 = 0x8877665544332211; ld at 0x28.
  - Required: dm_wordAddr=5, dm_byteOffset=0; resp_valid 1 cycle later; rdata=0x8877665544332211, fault=0.
- **Crossing lh.**
  - Stimulus: byte 0x07=0x80, byte 0x08=0xFF; lh at 0x07.
  - Required: two reads (word 0, then word 1); resp 2 cycles after accept with rdata=0xFFFFFFFFFFFFFF80. Same access with lhu gives 0x000000000000FF80.
- **Crossing sw.**
  - Stimulus: sw 0x11223344 at 0x06.
  - Required: four byte writes in consecutive cycles — (0,6)=0x44, (0,7)=0x33, (1,0)=0x22, (1,1)=0x11; resp 4 cycles after accept; word 0 bytes 0–5 and word 1 bytes 2–7 unchanged.
- **Fault.**
  - Stimulus: ld at 0x7FFC, then sb at 0x8000.
  - Required: no dm_readEnable/dm_writeEnable asserted; each gives resp_valid with fault=1, rdata=0, 1 cycle after accept.
- **Reset mid-split.**
  - Stimulus: sd at 0x03; assert reset after 2 byte writes.
  - Required: all outputs 0 and req_ready=1 immediately; no resp_valid; next aligned lw at 0x10 completes normally.
- **Back-to-back.**
  - Stimulus: req_valid held high with sb 0xAB at 0x20 followed by lbu at 0x20.
  - Required: req_ready low during RESP; second request accepted 2 cycles after the first; lbu returns 0xAB.
